// File: rtl/key_decoder.sv
// PS/2 set-2 scan-code decoder for a falling-block game: tracks six keys as held levels.
// Optional KEY_PRESS_PULSE_EN adds one-cycle make pulses on key_press; otherwise key_press is 0.
module key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] scan_code,
    output logic       key_valid,
    output logic       key_left,
    output logic       key_right,
    output logic       key_down,
    output logic       key_rotate,
    output logic       key_drop,
    output logic       key_hold,
    output logic [5:0] key_press
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_BAT_OK = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } state_t;

    state_t        state;
    logic [2:0]    skip_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [5:0]    held;
    logic [7:0]    scan_r;
    logic          valid_r;

    logic          ext_ctx;
    logic          make_evt;
    logic          break_evt;
    logic [5:0]    code_mask;
    logic [5:0]    make_mask;
    logic [5:0]    break_mask;
    logic [5:0]    held_next;

    // Held-bit order matches key_press: {hold, drop, rotate, down, right, left}.
    function automatic logic [5:0] decode(input logic [7:0] code, input logic ext);
        logic [5:0] m;
        m = '0;
        if (ext) begin
            case (code)
                8'h6B:   m = 6'b000001;
                8'h74:   m = 6'b000010;
                8'h72:   m = 6'b000100;
                8'h75:   m = 6'b001000;
                default: m = '0;
            endcase
        end else begin
            case (code)
                8'h29:   m = 6'b010000;
                8'h12:   m = 6'b100000;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    always_comb begin
        ext_ctx   = (state == EXT) || (state == EXT_BRK);
        code_mask = decode(rx_data, ext_ctx);
        make_evt  = 1'b0;
        break_evt = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE:    make_evt = (rx_data != CODE_EXT) && (rx_data != CODE_BRK) &&
                                    (rx_data != CODE_PAUSE) && (rx_data != CODE_ACK) &&
                                    (rx_data != CODE_BAT_OK);
                EXT:     make_evt = (rx_data != CODE_BRK);
                BRK:     break_evt = 1'b1;
                EXT_BRK: break_evt = 1'b1;
                default: begin
                    make_evt  = 1'b0;
                    break_evt = 1'b0;
                end
            endcase
        end
        make_mask  = make_evt  ? code_mask : '0;
        // Breaks of keys that are not held are masked out so they cannot touch scan_code.
        break_mask = break_evt ? (code_mask & held) : '0;
        held_next  = (held | make_mask) & ~break_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            timeout_cnt <= '0;
            held        <= '0;
            scan_r      <= '0;
            valid_r     <= 1'b0;
        end else begin
            held    <= held_next;
            valid_r <= |held_next;

            if (make_mask != '0) begin
                scan_r <= rx_data;
            end else if ((break_mask != '0) && (held_next == '0)) begin
                scan_r <= '0;
            end

            if (rx_valid) begin
                timeout_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (rx_data == CODE_EXT) begin
                            state <= EXT;
                        end else if (rx_data == CODE_BRK) begin
                            state <= BRK;
                        end else if (rx_data == CODE_PAUSE) begin
                            state    <= PAUSE;
                            skip_cnt <= 3'd7;
                        end
                    end
                    EXT: begin
                        state <= (rx_data == CODE_BRK) ? EXT_BRK : IDLE;
                    end
                    BRK:     state <= IDLE;
                    EXT_BRK: state <= IDLE;
                    PAUSE: begin
                        if (skip_cnt <= 3'd1) begin
                            skip_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            skip_cnt <= skip_cnt - 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // An abandoned partial sequence falls back to IDLE; held keys are left alone.
                if (timeout_cnt >= TIMEOUT_LAST) begin
                    state       <= IDLE;
                    skip_cnt    <= '0;
                    timeout_cnt <= '0;
                end else begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
        end
    end

`ifdef KEY_PRESS_PULSE_EN
    logic [5:0] press_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            press_r <= '0;
        end else begin
            press_r <= make_mask & ~held;
        end
    end

    assign key_press = press_r;
`else
    assign key_press = '0;
`endif

    assign scan_code  = scan_r;
    assign key_valid  = valid_r;
    assign key_left   = held[0];
    assign key_right  = held[1];
    assign key_down   = held[2];
    assign key_rotate = held[3];
    assign key_drop   = held[4];
    assign key_hold   = held[5];

endmodule

// File: doc/key_decoder.md
KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, maximum idle cycles in a partial sequence (prefix or Pause sequence) before the decoder aborts it.
REQ-002 clk  input  1  system clock, 100 MHz.
REQ-003 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 rx_data  input  8  received PS/2 byte, valid only when rx_valid=1.
REQ-005 rx_valid  input  1  one-cycle strobe per received byte.
REQ-006 scan_code  output  8  base code (prefix stripped) of the most recent make of a tracked key.
REQ-007 key_valid  output  1  at least one tracked key is held.
REQ-008 key_left, key_right, key_down, key_rotate, key_drop, key_hold  output  1 each  held level for each tracked key.
REQ-009 key_press  output  6  one-cycle make pulses in order {hold,drop,rotate,down,right,left}.

Function
REQ-010 Tracked keys: E0 6B=left, E0 74=right, E0 72=down, E0 75=rotate, 29=drop (space), 12=hold (left shift); all other codes change no key state.
REQ-011 FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (skipping the E1 sequence).
REQ-012 IDLE: E0->EXT; F0->BRK; E1->PAUSE with skip counter=7; any other byte is a non-extended make, decoded, stay IDLE.
REQ-013 EXT: F0->EXT_BRK; any other byte is an extended make, decoded, ->IDLE.
REQ-014 BRK: byte is a non-extended break, decoded, ->IDLE; EXT_BRK: byte is an extended break, decoded, ->IDLE.
REQ-015 PAUSE: each byte decrements the skip counter; when it reaches 0 ->IDLE; no key state changes.
REQ-016 E0 12 and E0 F0 12 (extended shift) shall not affect key_hold.
REQ-017 Bytes FA (ack) and AA (self-test pass) received in IDLE shall be ignored.
REQ-018 Make: held bit set on the cycle after rx_valid; scan_code updated on the same cycle; latency 1 cycle.
REQ-019 Break: held bit cleared 1 cycle after rx_valid; scan_code unchanged unless all keys are now released, then scan_code=00.
REQ-020 key_valid = OR of the six held bits, registered in the same cycle as those bits.
REQ-021 Typematic repeat (make of an already held key) shall leave held bits set and refresh scan_code.
REQ-022 A break for a key not held is a no-op.
REQ-023 Timeout counter resets on every rx_valid; it counts only in EXT, BRK, EXT_BRK and PAUSE; reaching TIMEOUT_CYCLES forces IDLE without changing key state.
REQ-024 If rx_valid and timeout occur in the same cycle, the byte is processed in the current state and the timeout is ignored.

Reset
REQ-025 While rst=1 on a clock edge: FSM=IDLE; counters=0; scan_code=00; key_valid=0; all key_* outputs=0; key_press=0.
REQ-026 Reset mid-sequence (for example after E0) discards the partial sequence; the next byte is decoded from IDLE.

Configuration
REQ-027 Macro KEY_PRESS_PULSE_EN defined: key_press bit pulses for exactly one cycle, coincident with the held bit rising 0->1; typematic repeats do not pulse.
REQ-028 Macro KEY_PRESS_PULSE_EN undefined: key_press is tied to 0; all other behaviour is identical.

Verification
REQ-029 Bytes E0,6B -> key_left=1, key_valid=1, scan_code=6B one cycle after the second strobe; then E0,F0,6B -> key_left=0, key_valid=0, scan_code=00.
REQ-030 Bytes 29, then 12, then F0,29 -> after the breaks key_drop=0, key_hold=1, key_valid=1, scan_code=12.
REQ-031 Bytes 29,29,29 with the macro defined -> key_press[4] pulses once only; key_drop stays 1.
REQ-032 Pause sequence E1,14,77,E1,F0,14,F0,77, then 12 -> no change during the sequence; key_hold=1 after the final 12.
REQ-033 E0, then no byte for TIMEOUT_CYCLES, then 6B -> FSM returns to IDLE; 6B is treated as non-extended; key_left stays 0.
REQ-034 E0, rst pulse, then 72 -> key_down stays 0; E0 12 -> key_hold stays 0.
